// File: rtl/aes_pkg.sv
// Shared AES types, sizes and the GF(2^8) multiply used by the S-box.
package aes_pkg;

  localparam int unsigned AES_STATE_BYTES = 16;
  localparam int unsigned AES_WORD_BYTES  = 4;
  localparam int unsigned AES_STATE_W     = AES_STATE_BYTES * 8;
  localparam int unsigned AES_WORD_W      = AES_WORD_BYTES * 8;

  typedef logic [7:0] aes_byte_t;

  typedef enum logic [2:0] {
    IDLE,
    RUN_RND,
    RUN_KEY,
    DONE_RND,
    DONE_KEY
  } sbox_sched_state_e;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic aes_byte_t gf_mul(aes_byte_t a, aes_byte_t b);
    aes_byte_t p;
    aes_byte_t x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox_sched_if.sv
// Request/response bundle between the round FSM / key scheduler and the S-box scheduler.
interface aes_sbox_sched_if;
  import aes_pkg::*;

  logic                   rnd_valid;
  logic                   rnd_ready;
  logic [AES_STATE_W-1:0] rnd_data;
  logic                   rnd_resp_valid;
  logic                   rnd_resp_ready;
  logic [AES_STATE_W-1:0] rnd_resp_data;
  logic                   key_valid;
  logic                   key_ready;
  logic [AES_WORD_W-1:0]  key_data;
  logic                   key_resp_valid;
  logic                   key_resp_ready;
  logic [AES_WORD_W-1:0]  key_resp_data;

  modport master (
    output rnd_valid, rnd_data, rnd_resp_ready, key_valid, key_data, key_resp_ready,
    input  rnd_ready, rnd_resp_valid, rnd_resp_data, key_ready, key_resp_valid, key_resp_data
  );

  modport slave (
    input  rnd_valid, rnd_data, rnd_resp_ready, key_valid, key_data, key_resp_ready,
    output rnd_ready, rnd_resp_valid, rnd_resp_data, key_ready, key_resp_valid, key_resp_data
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES S-box: multiplicative inverse (x^254) followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  aes_byte_t i_byte,
  output aes_byte_t o_sbox_c
);

  aes_byte_t w_inv;

  // x^254 = product of x^2, x^4, ..., x^128; maps 0 to 0 as required.
  always_comb begin
    aes_byte_t sq;
    sq    = i_byte;
    w_inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq    = gf_mul(sq, sq);
      w_inv = gf_mul(w_inv, sq);
    end
  end

  assign o_sbox_c = w_inv
                  ^ {w_inv[6:0], w_inv[7]}
                  ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]}
                  ^ {w_inv[3:0], w_inv[7:4]}
                  ^ 8'h63;

endmodule

// File: rtl/aes_sbox_sched.sv
// Shares LANES S-boxes between round SubBytes and key SubWord jobs, one job at a time.
module aes_sbox_sched
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic            clk,
  input  logic            rst,
  aes_sbox_sched_if.slave bus
);

  localparam int unsigned RND_BEATS = AES_STATE_BYTES / LANES;
  localparam int unsigned KEY_BEATS = AES_WORD_BYTES / LANES;
  localparam int unsigned BEAT_W    = 4;
  localparam int unsigned IDX_W     = 4;

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("aes_sbox_sched: LANES must be 1, 2 or 4");
  end

  sbox_sched_state_e      r_state, w_state_next;
  logic [AES_STATE_W-1:0] r_buf, w_buf_next, w_buf_wb;
  logic [BEAT_W-1:0]      r_beat, w_beat_next, w_last_beat;
  logic                   r_last_key, w_last_key_next;
  logic                   w_idle;

  logic [IDX_W-1:0] w_sel      [LANES];
  aes_byte_t        w_sbox_in  [LANES];
  aes_byte_t        w_sbox_out [LANES];

  // Lane l works on buffer byte beat*LANES + l.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_sel[l]     = IDX_W'(32'(r_beat) * LANES + 32'(l));
    assign w_sbox_in[l] = r_buf[{w_sel[l], 3'b000} +: 8];
    aes_sbox u_sbox (
      .i_byte   (w_sbox_in[l]),
      .o_sbox_c (w_sbox_out[l])
    );
  end

  always_comb begin
    w_buf_wb = r_buf;
    for (int l = 0; l < LANES; l++) begin
      w_buf_wb[{w_sel[l], 3'b000} +: 8] = w_sbox_out[l];
    end
  end

  assign w_idle      = (r_state == IDLE);
  assign w_last_beat = (r_state == RUN_RND) ? BEAT_W'(RND_BEATS - 1) : BEAT_W'(KEY_BEATS - 1);

  // Key wins a tie unless it also won the last grant and a round job is waiting.
  always_comb begin
    w_state_next    = r_state;
    w_buf_next      = r_buf;
    w_beat_next     = r_beat;
    w_last_key_next = r_last_key;
    bus.key_ready   = w_idle & ~(r_last_key & bus.rnd_valid);
    bus.rnd_ready   = w_idle & (~bus.key_valid | (r_last_key & bus.rnd_valid));
    case (r_state)
      IDLE: begin
        if (bus.key_valid && bus.key_ready) begin
          w_state_next    = RUN_KEY;
          w_buf_next      = AES_STATE_W'(bus.key_data);
          w_beat_next     = '0;
          w_last_key_next = 1'b1;
        end else if (bus.rnd_valid && bus.rnd_ready) begin
          w_state_next    = RUN_RND;
          w_buf_next      = bus.rnd_data;
          w_beat_next     = '0;
          w_last_key_next = 1'b0;
        end
      end
      RUN_RND, RUN_KEY: begin
        w_buf_next  = w_buf_wb;
        w_beat_next = BEAT_W'(r_beat + 1'b1);
        if (r_beat == w_last_beat) begin
          w_state_next = (r_state == RUN_RND) ? DONE_RND : DONE_KEY;
        end
      end
      DONE_RND: if (bus.rnd_resp_ready) w_state_next = IDLE;
      DONE_KEY: if (bus.key_resp_ready) w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_buf      <= '0;
      r_beat     <= '0;
      r_last_key <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_buf      <= w_buf_next;
      r_beat     <= w_beat_next;
      r_last_key <= w_last_key_next;
    end
  end

  assign bus.rnd_resp_valid = (r_state == DONE_RND);
  assign bus.rnd_resp_data  = bus.rnd_resp_valid ? r_buf : '0;
  assign bus.key_resp_valid = (r_state == DONE_KEY);
  assign bus.key_resp_data  = bus.key_resp_valid ? r_buf[AES_WORD_W-1:0] : '0;

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Directed bench for aes_sbox_sched: a LANES=4 instance plus a LANES=1 instance for key latency.
module tb_aes_sbox_sched;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  aes_sbox_sched_if if4 ();
  aes_sbox_sched_if if1 ();

  aes_sbox_sched #(.LANES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  aes_sbox_sched #(.LANES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  localparam logic [127:0] RND_IN  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] RND_OUT = 128'h76abd7fe2b670130c56f6bf27b777c63;

  task automatic test_reset();
    if4.rnd_valid = 0; if4.rnd_data = '0; if4.rnd_resp_ready = 0;
    if4.key_valid = 0; if4.key_data = '0; if4.key_resp_ready = 0;
    if1.rnd_valid = 0; if1.rnd_data = '0; if1.rnd_resp_ready = 0;
    if1.key_valid = 0; if1.key_data = '0; if1.key_resp_ready = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); @(negedge clk);
    n_vec++; if (if4.key_ready !== 1'b1) begin n_err++; $display("FAIL reset_key_ready: got %b expected 1", if4.key_ready); end
    n_vec++; if (if4.rnd_ready !== 1'b1) begin n_err++; $display("FAIL reset_rnd_ready: got %b expected 1", if4.rnd_ready); end
    n_vec++; if ({if4.rnd_resp_valid, if4.key_resp_valid} !== 2'b00) begin n_err++; $display("FAIL reset_resp_valid: got %b expected 00", {if4.rnd_resp_valid, if4.key_resp_valid}); end
    n_vec++; if (if4.rnd_resp_data !== '0) begin n_err++; $display("FAIL reset_rnd_data: got %h expected 0", if4.rnd_resp_data); end
    n_vec++; if (if4.key_resp_data !== '0) begin n_err++; $display("FAIL reset_key_data: got %h expected 0", if4.key_resp_data); end
    n_vec++; if (if1.key_ready !== 1'b1) begin n_err++; $display("FAIL reset_l1_key_ready: got %b expected 1", if1.key_ready); end
    if4.key_valid = 1'b1; #1;
    n_vec++; if (if4.rnd_ready !== 1'b0) begin n_err++; $display("FAIL reset_rnd_ready_kv: got %b expected 0", if4.rnd_ready); end
    if4.key_valid = 1'b0;
  endtask

  task automatic test_round();
    int lat;
    @(negedge clk);
    if4.rnd_data = RND_IN; if4.rnd_valid = 1'b1; if4.rnd_resp_ready = 1'b1;
    #1;
    n_vec++; if (if4.rnd_ready !== 1'b1) begin n_err++; $display("FAIL round_ready: got %b expected 1", if4.rnd_ready); end
    @(posedge clk); lat = 1;
    @(negedge clk); if4.rnd_valid = 1'b0;
    while (if4.rnd_resp_valid !== 1'b1 && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
    n_vec++; if (lat !== 5) begin n_err++; $display("FAIL round_latency: got %0d expected 5", lat); end
    n_vec++; if (if4.rnd_resp_data !== RND_OUT) begin n_err++; $display("FAIL round_data: got %h expected %h", if4.rnd_resp_data, RND_OUT); end
    @(posedge clk); @(negedge clk);
    n_vec++; if (if4.rnd_resp_valid !== 1'b0) begin n_err++; $display("FAIL round_valid_drop: got %b expected 0", if4.rnd_resp_valid); end
    n_vec++; if (if4.rnd_resp_data !== '0) begin n_err++; $display("FAIL round_data_off: got %h expected 0", if4.rnd_resp_data); end
  endtask

  task automatic test_key();
    int cyc, lat4, lat1;
    logic [31:0] d4, d1;
    @(negedge clk);
    if4.key_data = 32'hcf4f3c09; if4.key_valid = 1'b1; if4.key_resp_ready = 1'b1;
    if1.key_data = 32'hcf4f3c09; if1.key_valid = 1'b1; if1.key_resp_ready = 1'b1;
    #1;
    n_vec++; if ({if4.key_ready, if1.key_ready} !== 2'b11) begin n_err++; $display("FAIL key_ready: got %b expected 11", {if4.key_ready, if1.key_ready}); end
    @(posedge clk); cyc = 1;
    @(negedge clk); if4.key_valid = 1'b0; if1.key_valid = 1'b0;
    lat4 = 0; lat1 = 0; d4 = '0; d1 = '0;
    while ((lat4 == 0 || lat1 == 0) && cyc < 40) begin
      if (lat4 == 0 && if4.key_resp_valid === 1'b1) begin lat4 = cyc; d4 = if4.key_resp_data; end
      if (lat1 == 0 && if1.key_resp_valid === 1'b1) begin lat1 = cyc; d1 = if1.key_resp_data; end
      if (lat4 == 0 || lat1 == 0) begin @(posedge clk); cyc++; @(negedge clk); end
    end
    n_vec++; if (lat4 !== 2) begin n_err++; $display("FAIL key_latency_l4: got %0d expected 2", lat4); end
    n_vec++; if (d4 !== 32'h8a84eb01) begin n_err++; $display("FAIL key_data_l4: got %h expected 8a84eb01", d4); end
    n_vec++; if (lat1 !== 5) begin n_err++; $display("FAIL key_latency_l1: got %0d expected 5", lat1); end
    n_vec++; if (d1 !== 32'h8a84eb01) begin n_err++; $display("FAIL key_data_l1: got %h expected 8a84eb01", d1); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_contention();
    int cyc;
    logic got_key, exp_key;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); @(negedge clk); rst = 1'b0;
    if4.key_data = 32'h00000053; if4.key_valid = 1'b1; if4.key_resp_ready = 1'b1;
    if4.rnd_data = {8'h53, 112'h0, 8'hff}; if4.rnd_valid = 1'b1; if4.rnd_resp_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      exp_key = (j % 2 == 0);
      cyc = 0;
      while (!(if4.key_ready || if4.rnd_ready) && cyc < 20) begin @(posedge clk); @(negedge clk); cyc++; end
      got_key = if4.key_ready;
      n_vec++; if (got_key !== exp_key) begin n_err++; $display("FAIL contention_grant%0d: got key=%b expected key=%b", j, got_key, exp_key); end
      @(posedge clk); @(negedge clk); cyc = 0;
      while (!(if4.key_resp_valid || if4.rnd_resp_valid) && cyc < 20) begin @(posedge clk); @(negedge clk); cyc++; end
      if (exp_key) begin
        n_vec++; if (if4.key_resp_data !== 32'h636363ed) begin n_err++; $display("FAIL contention_key%0d: got %h expected 636363ed", j, if4.key_resp_data); end
      end else begin
        n_vec++; if (if4.rnd_resp_data !== {8'hed, {14{8'h63}}, 8'h16}) begin n_err++; $display("FAIL contention_rnd%0d: got %h expected %h", j, if4.rnd_resp_data, {8'hed, {14{8'h63}}, 8'h16}); end
      end
    end
    if4.key_valid = 1'b0; if4.rnd_valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_backpressure();
    int cyc;
    @(negedge clk);
    if4.rnd_resp_ready = 1'b0; if4.rnd_data = {16{8'hff}}; if4.rnd_valid = 1'b1;
    @(posedge clk); @(negedge clk); if4.rnd_valid = 1'b0;
    cyc = 0;
    while (if4.rnd_resp_valid !== 1'b1 && cyc < 20) begin @(posedge clk); @(negedge clk); cyc++; end
    for (int i = 0; i < 10; i++) begin
      n_vec++; if (if4.rnd_resp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid%0d: got %b expected 1", i, if4.rnd_resp_valid); end
      n_vec++; if (if4.rnd_resp_data !== {16{8'h16}}) begin n_err++; $display("FAIL bp_data%0d: got %h expected %h", i, if4.rnd_resp_data, {16{8'h16}}); end
      n_vec++; if ({if4.rnd_ready, if4.key_ready} !== 2'b00) begin n_err++; $display("FAIL bp_ready%0d: got %b expected 00", i, {if4.rnd_ready, if4.key_ready}); end
      @(posedge clk); @(negedge clk);
    end
    if4.rnd_resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    n_vec++; if (if4.rnd_resp_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b expected 0", if4.rnd_resp_valid); end
    n_vec++; if (if4.key_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_idle: got %b expected 1", if4.key_ready); end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    logic seen;
    @(negedge clk);
    if4.rnd_data = RND_IN; if4.rnd_valid = 1'b1; if4.rnd_resp_ready = 1'b1;
    @(posedge clk); @(negedge clk); if4.rnd_valid = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    n_vec++; if ({if4.rnd_resp_valid, if4.key_resp_valid} !== 2'b00) begin n_err++; $display("FAIL midrst_valid: got %b expected 00", {if4.rnd_resp_valid, if4.key_resp_valid}); end
    n_vec++; if (if4.rnd_resp_data !== '0) begin n_err++; $display("FAIL midrst_data: got %h expected 0", if4.rnd_resp_data); end
    n_vec++; if (if4.key_ready !== 1'b1) begin n_err++; $display("FAIL midrst_idle: got %b expected 1", if4.key_ready); end
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); @(negedge clk);
      seen = seen | if4.rnd_resp_valid | if4.key_resp_valid;
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_no_resp: got %b expected 0", seen); end
    if4.key_data = 32'hffffffff; if4.key_valid = 1'b1; if4.key_resp_ready = 1'b1;
    @(posedge clk); cyc = 1;
    @(negedge clk); if4.key_valid = 1'b0;
    while (if4.key_resp_valid !== 1'b1 && cyc < 40) begin @(posedge clk); cyc++; @(negedge clk); end
    n_vec++; if (cyc !== 2) begin n_err++; $display("FAIL midrst_key_latency: got %0d expected 2", cyc); end
    n_vec++; if (if4.key_resp_data !== 32'h16161616) begin n_err++; $display("FAIL midrst_key_data: got %h expected 16161616", if4.key_resp_data); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round();
    test_key();
    test_contention();
    test_backpressure();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
